sobol_seq_gen: RTL

Parametrised one-dimensional Sobol sequence generator built around a least-significant-zero (LSZ) detector. It generalises the fixed-width LSZ block to any WIDTH and embeds it in a sequential generator with:
- an internal index counter;
- a run-time loadable direction-vector table;
- enable and synchronous restart;
- a registered output and a wrap indicator.

---
 rtl/sobol_seq_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/sobol_seq_gen.sv
// One-dimensional Sobol sequence generator: an index counter, a least-significant-zero
// detector, and a run-time loadable direction table XORed into a registered output.
module sobol_seq_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LSZW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             vec_we,
    input  logic [LSZW-1:0]  vec_addr,
    input  logic [WIDTH-1:0] vec_data,
    output logic [WIDTH-1:0] rng_out,
    output logic [LSZW-1:0]  lsz_idx,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] vec [WIDTH];
    logic [LSZW-1:0]  lsz;
    logic [WIDTH-1:0] sel_vec;
    logic             cnt_full;

    // Lowest zero bit of cnt; WIDTH when cnt is all ones.
    always_comb begin
        lsz = LSZW'(WIDTH);
        for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
            if (!cnt[k]) begin
                lsz = LSZW'(k);
            end
        end
    end

    assign lsz_idx  = lsz;
    assign cnt_full = (lsz == LSZW'(WIDTH));

    // Direction vector selected by the LSZ index.
    always_comb begin
        sel_vec = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            if (lsz == LSZW'(k)) begin
                sel_vec = vec[k];
            end
        end
    end

    // Direction table; reset restores the van der Corput radical-inverse vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(WIDTH); k++) begin
                vec[k] <= WIDTH'(1) << (int'(WIDTH) - 1 - k);
            end
        end else if (vec_we) begin
            for (int k = 0; k < int'(WIDTH); k++) begin
                if (vec_addr == LSZW'(k)) begin
                    vec[k] <= vec_data;
                end
            end
        end
    end

    // Sequence state; any table write restarts so no mixed-table values are emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rng_out <= '0;
            wrap    <= 1'b0;
        end else if (clr || vec_we) begin
            cnt     <= '0;
            rng_out <= '0;
            wrap    <= 1'b0;
        end else if (en) begin
            if (cnt_full) begin
                cnt     <= '0;
                rng_out <= '0;
                wrap    <= 1'b1;
            end else begin
                cnt     <= cnt + WIDTH'(1);
                rng_out <= rng_out ^ sel_vec;
                wrap    <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
